// File: rtl/avst_pattern_gen_pkg.sv
// Shared types and constants for the Avalon-ST video test-pattern source.
// Latency: none (declarations only).
// Backpressure: not applicable.
package avst_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRID  = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CTRL_HDR  = 3'd1,
    ST_CTRL_DATA = 3'd2,
    ST_VID_HDR   = 3'd3,
    ST_VID_DATA  = 3'd4
  } state_e;

  localparam logic [3:0] PKT_TYPE_CTRL = 4'hF;
  localparam logic [3:0] PKT_TYPE_VID  = 4'h0;

  // width (4 nibbles), height (4 nibbles), interlace nibble
  localparam int CTRL_NIBBLES = 9;

  // Colour-bar lookup: returns {R,G,B} on/off bits for bar 0..7
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 3'b111; // white
      3'd1:    bar_rgb = 3'b110; // yellow
      3'd2:    bar_rgb = 3'b011; // cyan
      3'd3:    bar_rgb = 3'b010; // green
      3'd4:    bar_rgb = 3'b101; // magenta
      3'd5:    bar_rgb = 3'b100; // red
      3'd6:    bar_rgb = 3'b001; // blue
      default: bar_rgb = 3'b000; // black
    endcase
  endfunction

endpackage

// File: rtl/avst_pattern_pixel.sv
// Combinational pixel colour for one beat from pattern mode and position.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller holds inputs stable while stalled.
module avst_pattern_pixel
  import avst_pattern_gen_pkg::*;
#(
  parameter int BPS       = 8,
  parameter int GRID_LOG2 = 4
) (
  input  mode_e                  mode,
  input  logic [BPS-1:0]         ramp_v,
  input  logic [GRID_LOG2-1:0]   grid_x,
  input  logic [GRID_LOG2-1:0]   grid_y,
  input  logic [2:0]             bar_idx,
  input  logic [3*BPS-1:0]       solid,
  output logic [BPS-1:0]         pix_r,
  output logic [BPS-1:0]         pix_g,
  output logic [BPS-1:0]         pix_b
);

  logic [2:0] bar_bits;
  logic       grid_on;

  assign bar_bits = bar_rgb(bar_idx);
  assign grid_on  = (grid_x == '0) || (grid_y == '0);

  // Select the channel values for the active pattern
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    case (mode)
      MODE_BARS: begin
        pix_r = {BPS{bar_bits[2]}};
        pix_g = {BPS{bar_bits[1]}};
        pix_b = {BPS{bar_bits[0]}};
      end
      MODE_GRID: begin
        pix_r = {BPS{grid_on}};
        pix_g = {BPS{grid_on}};
        pix_b = {BPS{grid_on}};
      end
      MODE_RAMP: begin
        pix_r = ramp_v;
        pix_g = ramp_v;
        pix_b = ramp_v;
      end
      MODE_SOLID: begin
        {pix_r, pix_g, pix_b} = solid;
      end
      default: begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
      end
    endcase
  end

endmodule

// File: rtl/avst_pattern_gen.sv
// Avalon-ST Video pattern source: control packet then W*H-pixel video packet per frame; AVST_PATTERN_GEN_SCROLL_EN adds a per-frame horizontal scroll.
// Latency: first header beat valid the cycle after enable is sampled; back-to-back beats and frames with no bubbles.
// Backpressure: registered outputs hold while valid && !ready; FSM and counters advance only on an accepted beat.
module avst_pattern_gen
  import avst_pattern_gen_pkg::*;
#(
  parameter int BPS        = 8,
  parameter int SYMBOLS    = 3,
  parameter int MAX_WIDTH  = 1920,
  parameter int MAX_HEIGHT = 1080,
  parameter int GRID_LOG2  = 4
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [15:0]              width,
  input  logic [15:0]              height,
  input  logic [3*BPS-1:0]         solid_colour,
  output logic [SYMBOLS*BPS-1:0]   dout_data,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_sop,
  output logic                     dout_eop,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int CW         = $clog2(MAX_WIDTH + 1);
  localparam int HW         = $clog2(MAX_HEIGHT + 1);
  localparam int DW         = SYMBOLS * BPS;
  localparam int CTRL_BEATS = (CTRL_NIBBLES + SYMBOLS - 1) / SYMBOLS;
  localparam int CBW        = (CTRL_BEATS > 1) ? $clog2(CTRL_BEATS) : 1;

  state_e            state, state_n;
  mode_e             mode_q;
  logic [CW-1:0]     w_q, bar_w_q;
  logic [HW-1:0]     h_q;
  logic [3*BPS-1:0]  solid_q;

  logic [CBW-1:0]    cbeat, cbeat_n;
  logic [CW-1:0]     x, x_n, xp, xp_n, bcnt, bcnt_n;
  logic [HW-1:0]     y, y_n;
  logic [2:0]        bidx, bidx_n;

  // Per-line starting point of the displayed x' and its bar position
  logic [CW-1:0]     xs, bcnt_s;
  logic [2:0]        bidx_s;

  logic              acc, latch, last_px, line_end;
  logic [CW-1:0]     w_clamp, bar_w_calc;
  logic [HW-1:0]     h_clamp;

  logic [DW-1:0]     data_n, ctrl_dat;
  logic              valid_n, sop_n, eop_n;
  logic [BPS-1:0]    pix_r, pix_g, pix_b, ramp_v;
  logic [15:0]       w16, h16;
  logic [4*CTRL_NIBBLES-1:0] nib_vec;

  assign acc      = dout_valid && dout_ready;
  assign line_end = (x == w_q - 1'b1);
  assign last_px  = line_end && (y == h_q - 1'b1);
  assign busy     = (state != ST_IDLE);

  // Clamp the requested frame size into 1..MAX and derive the bar width
  always_comb begin
    w_clamp = '0;
    h_clamp = '0;
    if (width == 16'd0)                 w_clamp = CW'(1);
    else if (width > 16'(MAX_WIDTH))    w_clamp = CW'(MAX_WIDTH);
    else                                w_clamp = width[CW-1:0];
    if (height == 16'd0)                h_clamp = HW'(1);
    else if (height > 16'(MAX_HEIGHT))  h_clamp = HW'(MAX_HEIGHT);
    else                                h_clamp = height[HW-1:0];
    bar_w_calc = w_clamp >> 3;
    if (bar_w_calc == '0) bar_w_calc = CW'(1);
  end

`ifdef AVST_PATTERN_GEN_SCROLL_EN
  logic [15:0]   x_offset;
  logic [CW-1:0] xs_c, q_c, bcnt_c;
  logic [2:0]    bidx_c;

  // Scroll offset advances once per completed frame
  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      x_offset <= '0;
    else if (acc && (state == ST_VID_DATA) && last_px)
      x_offset <= x_offset + 1'b1;
  end

  // Locate the first displayed column of each line within the bar layout
  always_comb begin
    xs_c   = CW'(x_offset % 16'(w_q));
    q_c    = xs_c / bar_w_q;
    bidx_c = (q_c > CW'(7)) ? 3'd7 : q_c[2:0];
    bcnt_c = xs_c - CW'(bidx_c) * bar_w_q;
  end

  // Line-start values are settled while the control packet is still streaming
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      xs     <= '0;
      bidx_s <= '0;
      bcnt_s <= '0;
    end else if (state == ST_CTRL_DATA) begin
      xs     <= xs_c;
      bidx_s <= bidx_c;
      bcnt_s <= bcnt_c;
    end
  end
`else
  assign xs     = '0;
  assign bidx_s = '0;
  assign bcnt_s = '0;
`endif

  // Next-state and position counters; everything moves only on an accepted beat
  always_comb begin
    state_n = state;
    latch   = 1'b0;
    cbeat_n = cbeat;
    x_n     = x;
    xp_n    = xp;
    y_n     = y;
    bidx_n  = bidx;
    bcnt_n  = bcnt;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_n = ST_CTRL_HDR;
          latch   = 1'b1;
        end
      end
      ST_CTRL_HDR: begin
        if (acc) begin
          state_n = ST_CTRL_DATA;
          cbeat_n = '0;
        end
      end
      ST_CTRL_DATA: begin
        if (acc) begin
          if (cbeat == CBW'(CTRL_BEATS - 1)) state_n = ST_VID_HDR;
          else                              cbeat_n = cbeat + 1'b1;
        end
      end
      ST_VID_HDR: begin
        if (acc) begin
          state_n = ST_VID_DATA;
          x_n     = '0;
          y_n     = '0;
          xp_n    = xs;
          bidx_n  = bidx_s;
          bcnt_n  = bcnt_s;
        end
      end
      ST_VID_DATA: begin
        if (acc) begin
          if (last_px) begin
            state_n = enable ? ST_CTRL_HDR : ST_IDLE;
            latch   = enable;
          end else if (line_end) begin
            x_n    = '0;
            y_n    = y + 1'b1;
            xp_n   = xs;
            bidx_n = bidx_s;
            bcnt_n = bcnt_s;
          end else begin
            x_n = x + 1'b1;
            if (xp == w_q - 1'b1) begin
              // displayed column wraps back to the left edge mid-line
              xp_n   = '0;
              bidx_n = '0;
              bcnt_n = '0;
            end else begin
              xp_n = xp + 1'b1;
              if (bidx != 3'd7) begin
                if (bcnt == bar_w_q - 1'b1) begin
                  bidx_n = bidx + 1'b1;
                  bcnt_n = '0;
                end else begin
                  bcnt_n = bcnt + 1'b1;
                end
              end
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign w16     = 16'(w_q);
  assign h16     = 16'(h_q);
  assign nib_vec = {4'h0, h16[3:0], h16[7:4], h16[11:8], h16[15:12],
                          w16[3:0], w16[7:4], w16[11:8], w16[15:12]};

  // Spread control-packet nibbles over the symbols of the selected beat
  always_comb begin
    ctrl_dat = '0;
    for (int s = 0; s < SYMBOLS; s++) begin
      if (int'(cbeat_n) * SYMBOLS + s < CTRL_NIBBLES)
        ctrl_dat[s*BPS +: 4] = nib_vec[4*(int'(cbeat_n) * SYMBOLS + s) +: 4];
    end
  end

  assign ramp_v = BPS'(xp_n);

  avst_pattern_pixel #(
    .BPS       (BPS),
    .GRID_LOG2 (GRID_LOG2)
  ) u_pixel (
    .mode    (mode_q),
    .ramp_v  (ramp_v),
    .grid_x  (xp_n[GRID_LOG2-1:0]),
    .grid_y  (y_n[GRID_LOG2-1:0]),
    .bar_idx (bidx_n),
    .solid   (solid_q),
    .pix_r   (pix_r),
    .pix_g   (pix_g),
    .pix_b   (pix_b)
  );

  // Build the beat that will be presented in the next state
  always_comb begin
    data_n  = '0;
    valid_n = 1'b0;
    sop_n   = 1'b0;
    eop_n   = 1'b0;
    case (state_n)
      ST_CTRL_HDR: begin
        valid_n     = 1'b1;
        sop_n       = 1'b1;
        data_n[3:0] = PKT_TYPE_CTRL;
      end
      ST_CTRL_DATA: begin
        valid_n = 1'b1;
        data_n  = ctrl_dat;
        eop_n   = (cbeat_n == CBW'(CTRL_BEATS - 1));
      end
      ST_VID_HDR: begin
        valid_n     = 1'b1;
        sop_n       = 1'b1;
        data_n[3:0] = PKT_TYPE_VID;
      end
      ST_VID_DATA: begin
        valid_n             = 1'b1;
        data_n[3*BPS-1:0]   = {pix_r, pix_g, pix_b};
        for (int s = 3; s < SYMBOLS; s++)
          data_n[s*BPS +: BPS] = '1;
        eop_n = (x_n == w_q - 1'b1) && (y_n == h_q - 1'b1);
      end
      default: begin
        valid_n = 1'b0;
      end
    endcase
  end

  // FSM state and position counters
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= ST_IDLE;
      cbeat <= '0;
      x     <= '0;
      xp    <= '0;
      y     <= '0;
      bidx  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      cbeat <= cbeat_n;
      x     <= x_n;
      xp    <= xp_n;
      y     <= y_n;
      bidx  <= bidx_n;
      bcnt  <= bcnt_n;
    end
  end

  // Frame parameters are captured only at a frame boundary
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mode_q  <= MODE_BARS;
      w_q     <= '0;
      h_q     <= '0;
      bar_w_q <= '0;
      solid_q <= '0;
    end else if (latch) begin
      mode_q  <= mode_e'(mode);
      w_q     <= w_clamp;
      h_q     <= h_clamp;
      bar_w_q <= bar_w_calc;
      solid_q <= solid_colour;
    end
  end

  // Output register: reloads when empty or when the current beat is taken
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
    end else if (!dout_valid || dout_ready) begin
      dout_valid <= valid_n;
      dout_data  <= data_n;
      dout_sop   <= sop_n;
      dout_eop   <= eop_n;
    end
  end

  // Pulse once when the final pixel of a frame is accepted
  always_ff @(posedge clk_clk) begin
    if (reset_reset) frame_done <= 1'b0;
    else             frame_done <= acc && (state == ST_VID_DATA) && last_px;
  end

endmodule

// File: tb/tb_avst_pattern_gen.sv
// Self-checking bench for avst_pattern_gen: scoreboard of expected beats.
// Latency: checks first-beat timing and zero-bubble streaming.
// Backpressure: random ready with hold-stability checks.
module tb_avst_pattern_gen;

  localparam int BPS = 8;
  localparam int SYMBOLS = 3;
  localparam int DW = SYMBOLS * BPS;
  localparam int MAXW = 1920;
  localparam int MAXH = 1080;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [1:0]      mode;
  logic [15:0]     width, height;
  logic [23:0]     solid_colour;
  logic [DW-1:0]   dout_data;
  logic            dout_valid, dout_ready, dout_sop, dout_eop;
  logic            frame_done, busy;

  beat_t sb[$];
  int    n_cmp = 0, n_bad = 0;
  int    fd_cnt = 0, xfer_cnt = 0, cyc = 0, first_xfer = 0, last_xfer = 0;
  logic  fd_busy = 1'b0;
  logic  rand_rdy = 1'b0;
  int    m_off = 0;
  logic [2:0] bar_lut [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                              3'b101, 3'b100, 3'b001, 3'b000};

  always #5 clk = ~clk;

  avst_pattern_gen #(
    .BPS(BPS), .SYMBOLS(SYMBOLS), .MAX_WIDTH(MAXW), .MAX_HEIGHT(MAXH), .GRID_LOG2(4)
  ) dut (
    .clk_clk(clk), .reset_reset(reset), .enable(enable), .mode(mode),
    .width(width), .height(height), .solid_colour(solid_colour),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .frame_done(frame_done), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: push every beat of one frame onto the scoreboard
  task automatic push_frame(input int md, input int wi, input int hi, input logic [23:0] sol);
    int w, h, bw, xp, idx;
    logic [15:0] w16, h16;
    logic [3:0]  nib [9];
    logic [7:0]  r, g, b, v;
    logic        on;
    beat_t       bt;
    w = (wi == 0) ? 1 : ((wi > MAXW) ? MAXW : wi);
    h = (hi == 0) ? 1 : ((hi > MAXH) ? MAXH : hi);
    w16 = w[15:0];
    h16 = h[15:0];
    nib = '{w16[15:12], w16[11:8], w16[7:4], w16[3:0],
            h16[15:12], h16[11:8], h16[7:4], h16[3:0], 4'h0};
    bt = '0; bt.data[3:0] = 4'hF; bt.sop = 1'b1;
    sb.push_back(bt);
    for (int k = 0; k < 3; k++) begin
      bt = '0;
      for (int s = 0; s < SYMBOLS; s++)
        if (k * SYMBOLS + s < 9) bt.data[s*BPS +: 4] = nib[k * SYMBOLS + s];
      bt.eop = (k == 2);
      sb.push_back(bt);
    end
    bt = '0; bt.sop = 1'b1;
    sb.push_back(bt);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        xp = (xx + m_off) % w;
        r = 0; g = 0; b = 0;
        case (md)
          0: begin
            bw = w >> 3;
            if (bw == 0) bw = 1;
            idx = xp / bw;
            if (idx > 7) idx = 7;
            r = {8{bar_lut[idx][2]}}; g = {8{bar_lut[idx][1]}}; b = {8{bar_lut[idx][0]}};
          end
          1: begin
            on = ((xp % 16) == 0) || ((yy % 16) == 0);
            r = {8{on}}; g = {8{on}}; b = {8{on}};
          end
          2: begin
            v = 8'(xp % 256);
            r = v; g = v; b = v;
          end
          default: {r, g, b} = sol;
        endcase
        bt = '0;
        bt.data = {r, g, b};
        bt.eop = (xx == w - 1) && (yy == h - 1);
        sb.push_back(bt);
      end
    end
`ifdef AVST_PATTERN_GEN_SCROLL_EN
    m_off++;
`endif
  endtask

  // Monitor: drives ready, checks stalls, pops scoreboard on every transfer
  initial begin
    beat_t e;
    logic  stall_prev;
    beat_t prev;
    stall_prev = 1'b0;
    prev = '0;
    dout_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (frame_done) begin
          fd_cnt++;
          fd_busy = busy;
        end
        if (stall_prev) begin
          check("hold_valid", dout_valid, 1);
          check("hold_data", dout_data, prev.data);
          check("hold_sop", dout_sop, prev.sop);
          check("hold_eop", dout_eop, prev.eop);
        end
      end
      dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!reset && dout_valid && dout_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("beat_data", dout_data, e.data);
          check("beat_sop", dout_sop, e.sop);
          check("beat_eop", dout_eop, e.eop);
        end
        if (xfer_cnt == 0) first_xfer = cyc;
        last_xfer = cyc;
        xfer_cnt++;
      end
      stall_prev = !reset && dout_valid && !dout_ready;
      prev.data = dout_data; prev.sop = dout_sop; prev.eop = dout_eop;
    end
  end

  task automatic cfg(input int md, input int w, input int h, input logic [23:0] sol);
    mode = 2'(md); width = 16'(w); height = 16'(h); solid_colour = sol;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    check("early_valid", dout_valid, 0);
    @(negedge clk);
    check("first_valid", dout_valid, 1);
    check("first_sop", dout_sop, 1);
    check("busy_up", busy, 1);
  endtask

  task automatic wait_fd(input int target, input string tag);
    int c;
    c = 0;
    while (fd_cnt < target && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, fd_cnt >= target, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, c;
    reset = 1'b1; enable = 1'b0;
    cfg(0, 16, 4, 24'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", dout_valid, 0);
    check("rst_sop", dout_sop, 0);
    check("rst_eop", dout_eop, 0);
    check("rst_data", dout_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    idle(2);

    // Two back-to-back bar frames, ready held high
    rand_rdy = 1'b0;
    push_frame(0, 16, 4, 0);
    push_frame(0, 16, 4, 0);
    xfer_cnt = 0; base = fd_cnt;
    start_frame();
    wait_fd(base + 1, "t1_frame1");
    enable = 1'b0;
    wait_fd(base + 2, "t1_frame2");
    idle(4);
    check("t1_xfers", xfer_cnt, 138);
    check("t1_no_bubbles", last_xfer - first_xfer + 1, 138);
    check("t1_sb_empty", sb.size(), 0);

    // Same stream under random backpressure
    rand_rdy = 1'b1;
    push_frame(0, 16, 4, 0);
    push_frame(0, 16, 4, 0);
    base = fd_cnt;
    start_frame();
    wait_fd(base + 1, "t2_frame1");
    enable = 1'b0;
    wait_fd(base + 2, "t2_frame2");
    idle(4);
    check("t2_sb_empty", sb.size(), 0);

    // Clamping: width 0 -> 1, height 5000 -> MAX
    rand_rdy = 1'b0;
    cfg(1, 0, 5000, 0);
    push_frame(1, 0, 5000, 0);
    xfer_cnt = 0; base = fd_cnt;
    start_frame();
    enable = 1'b0;
    wait_fd(base + 1, "t3_frame");
    idle(4);
    check("t3_xfers", xfer_cnt, 5 + MAXH);
    check("t3_sb_empty", sb.size(), 0);

    // Narrow bars and a wrapping ramp
    rand_rdy = 1'b1;
    cfg(0, 13, 2, 0);
    push_frame(0, 13, 2, 0);
    base = fd_cnt;
    start_frame();
    enable = 1'b0;
    wait_fd(base + 1, "t4_bars");
    cfg(2, 300, 1, 0);
    push_frame(2, 300, 1, 0);
    start_frame();
    enable = 1'b0;
    wait_fd(base + 2, "t4_ramp");
    cfg(1, 40, 20, 0);
    push_frame(1, 40, 20, 0);
    start_frame();
    enable = 1'b0;
    wait_fd(base + 3, "t4_grid");
    idle(4);
    check("t4_sb_empty", sb.size(), 0);

    // Inputs changed and enable dropped mid-frame
    cfg(0, 16, 4, 0);
    push_frame(0, 16, 4, 0);
    base = fd_cnt;
    start_frame();
    enable = 1'b0;
    cfg(3, 8, 2, 24'h123456);
    wait_fd(base + 1, "t5_frame");
    check("t5_busy_low", fd_busy, 0);
    idle(6);
    check("t5_done_once", fd_cnt, base + 1);
    check("t5_idle", busy, 0);
    push_frame(3, 8, 2, 24'h123456);
    start_frame();
    enable = 1'b0;
    wait_fd(base + 2, "t5_solid");
    idle(4);
    check("t5_sb_empty", sb.size(), 0);

    // Reset in the middle of the video packet
    cfg(0, 16, 4, 0);
    push_frame(0, 16, 4, 0);
    xfer_cnt = 0;
    start_frame();
    enable = 1'b0;
    c = 0;
    while (xfer_cnt < 12 && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    check("t5_rst_reach", xfer_cnt >= 12, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_valid", dout_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_sop", dout_sop, 0);
    sb.delete();
    m_off = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    cfg(3, 5, 3, 24'hA5C300);
    push_frame(3, 5, 3, 24'hA5C300);
    base = fd_cnt;
    start_frame();
    enable = 1'b0;
    wait_fd(base + 1, "t5_restart");
    idle(4);
    check("t5_restart_sb", sb.size(), 0);

    // Ramp frames: pixel 0 follows the scroll offset when enabled
    rand_rdy = 1'b0;
    cfg(2, 16, 1, 0);
    for (int n = 0; n < 4; n++) begin
      push_frame(2, 16, 1, 0);
      base = fd_cnt;
      start_frame();
      enable = 1'b0;
      wait_fd(base + 1, "t6_frame");
      idle(2);
    end
    idle(4);
    check("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
